accumulation_unit: RTL and testbench
====================================

Name: accumulation_unit

Overview:
- Downstream consumer of the accumulation counter's `end_o`.
- Sums signed PE results over one accumulation window and closes the window on the counter's end pulse.
- Pushes each finished sum into a small output FIFO, drained by the output-stream stage through a valid/ready handshake.
- Sits in the execute stage between the PE array result path and the output stream interface.

Parameters:
- DATA_WIDTH, 32, width of signed PE result `data_i`.
- ACC_WIDTH, 40, width of accumulator and of `acc_data_o`; must be >= DATA_WIDTH.
- FIFO_DEPTH, 2, number of finished sums buffered; power of two, >= 2.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset: asynchronous, active-high.
- state_i  in  state_t  global MAGE state; accumulation only in EXEC.
- data_i  in  DATA_WIDTH  signed PE result.
- data_valid_i  in  1  `data_i` is valid this cycle (one per II slot).
- end_i  in  1  window-end flag from the accumulation counter (`end_o`); qualifies the current valid sample as the last of its window.
- acc_data_o  out  ACC_WIDTH  head-of-FIFO finished sum.
- acc_valid_o  out  1  FIFO not empty.
- acc_ready_i  in  1  consumer accepts head when `acc_valid_o`=1.
- drop_o  out  1  sticky: a finished sum was lost because the FIFO was full.
- busy_o  out  1  high in ACC state, or while the FIFO is non-empty.

Behaviour:
- Reset (async, rst_i=1):
  - acc=0, FSM=IDLE, FIFO empty.
  - `acc_valid_o`=0, `acc_data_o`=0, `drop_o`=0, `busy_o`=0.
- FSM states: IDLE, ACC, DRAIN.
  - IDLE -> ACC when `state_i`==EXEC.
  - ACC -> DRAIN when `state_i`!=EXEC and FIFO non-empty.
  - ACC -> IDLE when `state_i`!=EXEC and FIFO empty.
  - DRAIN -> IDLE when FIFO becomes empty.
  - DRAIN -> ACC if `state_i` returns to EXEC.
- Accumulator:
  - In ACC, when `data_valid_i`=1 and `end_i`=0: acc <= acc + sext(`data_i`).
  - `data_valid_i`=1 with `end_i`=1: sum = acc + sext(`data_i`) is pushed to the FIFO, and acc <= 0, in the same cycle.
  - `end_i`=1 with `data_valid_i`=0: no push; acc unchanged. `end_i` is ignored unless qualified.
  - `data_valid_i` outside ACC: ignored.
  - Leaving EXEC clears acc (partial window discarded); the FIFO is kept.
- Arithmetic: signed two's complement at ACC_WIDTH; wraps on overflow (see optional feature).
- FIFO:
  - Pushed sum visible on `acc_data_o` with `acc_valid_o`=1 the cycle after push (latency 1).
  - Pop when `acc_valid_o` && `acc_ready_i`.
  - Push to full FIFO with simultaneous pop: both succeed; occupancy unchanged.
  - Push to full FIFO without pop: sum discarded, `drop_o` <= 1 (sticky until reset).
  - Empty: `acc_data_o` holds last popped value; `acc_valid_o`=0.
- `busy_o` = (FSM==ACC) | `acc_valid_o`; registered FSM, combinational OR.
- Reset mid-operation: everything returns to reset values immediately, including buffered sums.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: the adder saturates to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) on signed overflow, including the final push sum. An extra output port `sat_o` (1 bit, sticky until reset) flags that saturation occurred.
- Undefined: wrap-around arithmetic; `sat_o` port absent.

Decomposition:
- mage_pkg: acc_fsm_t enum {IDLE, ACC, DRAIN}; default constants ACC_DATA_WIDTH=32, ACC_WIDTH=40, ACC_FIFO_DEPTH=2.
- `state_t` and EXEC come from existing pea_pkg/mage_pkg.
- One sub-module, acc_out_fifo: synchronous FIFO with push/pop/full/empty, parameterised by width and depth.

Test Plan:
- EXEC, samples 3, -1, 5, 7 with `end_i` on the 4th, `acc_ready_i`=1 -> `acc_data_o`=14, `acc_valid_o` pulse one cycle after the 4th sample; next window starts from 0.
- `acc_ready_i`=0, three windows each ending in sum 1 (FIFO_DEPTH=2) -> first two sums buffered, third dropped, `drop_o`=1; release ready -> pops 1, 1 then `acc_valid_o`=0.
- FIFO full, simultaneous push 9 and pop -> no drop; output order preserved; `drop_o` stays 0.
- Window with samples 10, 20, then `state_i` leaves EXEC before `end_i`, one sum (4) buffered -> FSM=DRAIN, `busy_o`=1 until pop, 30 never emitted, next EXEC window starts at 0.
- Assert `rst_i` while FIFO holds 2 entries and acc=50 -> next cycle `acc_valid_o`=0, `drop_o`=0, `busy_o`=0; after release, a window ending 2 yields 2.
- ACC_WIDTH=40, add 0x7FFFFFFF repeatedly past 2^39 -> wraps negative without the macro; with ACC_SATURATE_EN clamps to 0x7FFFFFFFFF and `sat_o`=1.

Source files
------------

// File: rtl/mage_pkg.sv
// Shared MAGE types and default sizing for the accumulation unit.
package mage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONF,
        EXEC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN
    } acc_fsm_t;

    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACC_WIDTH      = 40;
    localparam int ACC_FIFO_DEPTH = 2;

endpackage

// File: rtl/acc_out_fifo.sv
// Small synchronous FIFO for finished sums; a push into a full FIFO only
// lands when the same cycle pops. The head holds the last popped value when empty.
module acc_out_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_last;
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o   = (r_wr == r_rd);
    assign full_o    = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign data_o    = empty_o ? r_last : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_last <= '0;
        end else begin
            if (w_push_ok)
                r_wr <= r_wr + (AW+1)'(1);
            if (w_pop_ok) begin
                r_rd   <= r_rd + (AW+1)'(1);
                r_last <= r_mem[r_rd[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok)
            r_mem[r_wr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/accumulation_unit.sv
// Sums signed PE results per accumulation window and queues finished sums
// for the output stream. Optional saturating arithmetic via ACC_SATURATE_EN.
module accumulation_unit
    import mage_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int ACC_WIDTH  = mage_pkg::ACC_WIDTH,
    parameter int FIFO_DEPTH = ACC_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  state_t                state_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  end_i,
    output logic [ACC_WIDTH-1:0]  acc_data_o,
    output logic                  acc_valid_o,
    input  logic                  acc_ready_i,
    output logic                  drop_o,
    output logic                  busy_o
`ifdef ACC_SATURATE_EN
    ,
    output logic                  sat_o
`endif
);

    acc_fsm_t              r_state;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_drop;
    logic                  w_exec;
    logic                  w_active;
    logic [ACC_WIDTH-1:0]  w_sext;
    logic [ACC_WIDTH-1:0]  w_raw;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    assign w_exec   = (state_i == EXEC);
    assign w_active = (r_state == ACC) && w_exec;
    assign w_sext   = ACC_WIDTH'(signed'(data_i));
    assign w_raw    = r_acc + w_sext;

`ifdef ACC_SATURATE_EN
    logic w_ovf;
    logic r_sat;

    // Overflow only when both operands share a sign the result lost.
    assign w_ovf = (r_acc[ACC_WIDTH-1] == w_sext[ACC_WIDTH-1]) &&
                   (w_raw[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_sum = !w_ovf ? w_raw :
                   r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign sat_o = r_sat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_sat <= 1'b0;
        else if (w_active && data_valid_i && w_ovf)
            r_sat <= 1'b1;
    end
`else
    assign w_sum = w_raw;
`endif

    assign w_push = w_active && data_valid_i && end_i;
    assign w_pop  = acc_valid_o && acc_ready_i;

    acc_out_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_sum),
        .pop_i   (w_pop),
        .data_o  (acc_data_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign acc_valid_o = !w_empty;
    assign drop_o      = r_drop;
    assign busy_o      = (r_state == ACC) | acc_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop)
                r_drop <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_acc <= '0;
                    if (w_exec)
                        r_state <= ACC;
                end
                ACC: begin
                    // A partial window is discarded when EXEC ends.
                    if (!w_exec) begin
                        r_acc   <= '0;
                        r_state <= w_empty ? IDLE : DRAIN;
                    end else if (data_valid_i) begin
                        r_acc <= end_i ? '0 : w_sum;
                    end
                end
                DRAIN: begin
                    r_acc <= '0;
                    if (w_exec)
                        r_state <= ACC;
                    else if (w_empty)
                        r_state <= IDLE;
                end
                default: begin
                    r_acc   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulation_unit.sv
// Directed bench for accumulation_unit; expectations are hand-computed.
// Build with ACC_SATURATE_EN defined to cover the saturating variant.
module tb_accumulation_unit;
    import mage_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    state_t       state_i = ST_IDLE;
    logic [31:0]  data_i = '0;
    logic         data_valid_i = 1'b0;
    logic         end_i = 1'b0;
    logic [39:0]  acc_data_o;
    logic         acc_valid_o;
    logic         acc_ready_i = 1'b0;
    logic         drop_o;
    logic         busy_o;
`ifdef ACC_SATURATE_EN
    logic         sat_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    accumulation_unit #(
        .DATA_WIDTH (32),
        .ACC_WIDTH  (40),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .state_i      (state_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .end_i        (end_i),
        .acc_data_o   (acc_data_o),
        .acc_valid_o  (acc_valid_o),
        .acc_ready_i  (acc_ready_i),
        .drop_o       (drop_o),
        .busy_o       (busy_o)
`ifdef ACC_SATURATE_EN
        ,
        .sat_o        (sat_o)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample(input logic [31:0] d, input logic e);
        data_i       = d;
        data_valid_i = 1'b1;
        end_i        = e;
        step();
        data_valid_i = 1'b0;
        end_i        = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #3;
        n_checks++; if (acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", acc_valid_o); end
        n_checks++; if (acc_data_o !== 40'd0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", acc_data_o); end
        n_checks++; if (drop_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
`ifdef ACC_SATURATE_EN
        n_checks++; if (sat_o !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat_o); end
`endif
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic_window();
        acc_ready_i = 1'b1;
        state_i = EXEC;
        step();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_acc: got %b want 1", busy_o); end
        sample(32'd3, 1'b0);
        sample(-32'sd1, 1'b0);
        sample(32'd5, 1'b0);
        n_checks++; if (acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", acc_valid_o); end
        sample(32'd7, 1'b1);
        n_checks++; if (acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", acc_valid_o); end
        n_checks++; if (acc_data_o !== 40'd14) begin n_fail++; $display("FAIL basic_sum: got %0d want 14", acc_data_o); end
        step();
        n_checks++; if (acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", acc_valid_o); end
        // end without a valid sample must not push
        end_i = 1'b1;
        step();
        end_i = 1'b0;
        n_checks++; if (acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_end_unqual: got %b want 0", acc_valid_o); end
        sample(32'd1, 1'b1);
        n_checks++; if (acc_data_o !== 40'd1) begin n_fail++; $display("FAIL basic_next_window: got %0d want 1", acc_data_o); end
        step();
    endtask

    task automatic test_drop();
        acc_ready_i = 1'b0;
        sample(32'd1, 1'b1);
        sample(32'd1, 1'b1);
        n_checks++; if (drop_o !== 1'b0) begin n_fail++; $display("FAIL drop_early: got %b want 0", drop_o); end
        sample(32'd1, 1'b1);
        n_checks++; if (drop_o !== 1'b1) begin n_fail++; $display("FAIL drop_set: got %b want 1", drop_o); end
        n_checks++; if (acc_valid_o !== 1'b1 || acc_data_o !== 40'd1) begin n_fail++; $display("FAIL drop_head: got v=%b d=%0d want v=1 d=1", acc_valid_o, acc_data_o); end
        acc_ready_i = 1'b1;
        step();
        n_checks++; if (acc_valid_o !== 1'b1 || acc_data_o !== 40'd1) begin n_fail++; $display("FAIL drop_second: got v=%b d=%0d want v=1 d=1", acc_valid_o, acc_data_o); end
        step();
        n_checks++; if (acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_drained: got %b want 0", acc_valid_o); end
        n_checks++; if (drop_o !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", drop_o); end
    endtask

    task automatic test_full_pop();
        do_reset();
        state_i = EXEC;
        step();
        acc_ready_i = 1'b0;
        sample(32'd5, 1'b1);
        sample(32'd6, 1'b1);
        n_checks++; if (acc_data_o !== 40'd5) begin n_fail++; $display("FAIL full_head: got %0d want 5", acc_data_o); end
        acc_ready_i = 1'b1;
        sample(32'd9, 1'b1);
        n_checks++; if (acc_data_o !== 40'd6 || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_pop1: got v=%b d=%0d want v=1 d=6", acc_valid_o, acc_data_o); end
        n_checks++; if (drop_o !== 1'b0) begin n_fail++; $display("FAIL full_nodrop: got %b want 0", drop_o); end
        step();
        n_checks++; if (acc_data_o !== 40'd9 || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_pop2: got v=%b d=%0d want v=1 d=9", acc_valid_o, acc_data_o); end
        step();
        n_checks++; if (acc_valid_o !== 1'b0 || acc_data_o !== 40'd9) begin n_fail++; $display("FAIL full_hold: got v=%b d=%0d want v=0 d=9", acc_valid_o, acc_data_o); end
    endtask

    task automatic test_drain();
        acc_ready_i = 1'b0;
        sample(32'd4, 1'b1);
        sample(32'd10, 1'b0);
        sample(32'd20, 1'b0);
        state_i = ST_IDLE;
        step();
        n_checks++; if (busy_o !== 1'b1 || acc_data_o !== 40'd4) begin n_fail++; $display("FAIL drain_busy: got b=%b d=%0d want b=1 d=4", busy_o, acc_data_o); end
        step();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drain_hold: got %b want 1", busy_o); end
        acc_ready_i = 1'b1;
        step();
        n_checks++; if (busy_o !== 1'b0 || acc_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_done: got b=%b v=%b want 0 0", busy_o, acc_valid_o); end
        step();
        state_i = EXEC;
        step();
        sample(32'd2, 1'b1);
        n_checks++; if (acc_data_o !== 40'd2 || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_fresh: got v=%b d=%0d want v=1 d=2", acc_valid_o, acc_data_o); end
        step();
    endtask

    task automatic test_reset_mid();
        acc_ready_i = 1'b0;
        sample(32'd3, 1'b1);
        sample(32'd4, 1'b1);
        sample(32'd5, 1'b1);
        sample(32'd20, 1'b0);
        sample(32'd30, 1'b0);
        n_checks++; if (drop_o !== 1'b1 || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got dr=%b v=%b want 1 1", drop_o, acc_valid_o); end
        rst_i = 1'b1;
        #2;
        n_checks++; if (acc_valid_o !== 1'b0 || drop_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%b dr=%b b=%b want 0 0 0", acc_valid_o, drop_o, busy_o); end
        n_checks++; if (acc_data_o !== 40'd0) begin n_fail++; $display("FAIL mid_reset_data: got %0d want 0", acc_data_o); end
        step();
        rst_i = 1'b0;
        step();
        acc_ready_i = 1'b1;
        sample(32'd2, 1'b1);
        n_checks++; if (acc_data_o !== 40'd2 || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_after: got v=%b d=%0d want v=1 d=2", acc_valid_o, acc_data_o); end
        step();
    endtask

    task automatic test_overflow();
        logic [39:0] exp_sum;
`ifdef ACC_SATURATE_EN
        exp_sum = 40'h7F_FFFF_FFFF;
`else
        exp_sum = 40'h80_7FFF_FEFF;
`endif
        acc_ready_i = 1'b1;
        for (int i = 0; i < 256; i++)
            sample(32'h7FFF_FFFF, 1'b0);
        sample(32'h7FFF_FFFF, 1'b1);
        n_checks++; if (acc_data_o !== exp_sum || acc_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sum: got v=%b d=%0h want v=1 d=%0h", acc_valid_o, acc_data_o, exp_sum); end
`ifdef ACC_SATURATE_EN
        n_checks++; if (sat_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sat: got %b want 1", sat_o); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_drop();
        test_full_pop();
        test_drain();
        test_reset_mid();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
